// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction constants and the fetch-to-decode entry type.
package cpu_pkg;

   localparam int INSTR_W      = 16;
   localparam int FETCH_ADDR_W = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hBF00;
   localparam logic [3:0]         PC_ADDR   = 4'b1111;

   typedef struct packed {
      logic [INSTR_W-1:0]      instr;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO of fetch entries. The head is visible whenever count is
// non-zero, and flush takes priority over push and pop.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fetch_entry_t  push_entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push_s, do_pop_s;

   // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      do_pop_s  = pop && (count_q != {CW{1'b0}});
      do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      if (flush) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: it is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush && !reset) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads a synchronous instruction memory
// and hands instructions to the decoder through a prefetch FIFO and valid/ready.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;

   logic [CW-1:0]     fifo_count_s;
   fetch_entry_t      head_s, push_entry_s;
   logic              room_s, issue_s, push_s, pop_s, valid_s;

   // Issue/handshake control. The room test counts the outstanding read but ignores
   // any same-cycle pop, so an issued read always has a slot waiting for it.
   always_comb begin
      room_s  = ({1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
      issue_s = !reset && !redirect && !halt && room_s;
      valid_s = (fifo_count_s != {CW{1'b0}});
      push_s  = inflight_q && !redirect;
      pop_s   = valid_s && instr_ready && !redirect;

      push_entry_s.instr = imem_rdata;
      push_entry_s.pc    = FETCH_ADDR_W'(inflight_pc_q);

      imem_en     = issue_s;
      imem_addr   = fetch_pc_q;
      instr_valid = valid_s;
      if (valid_s) begin
         instruction = head_s.instr;
         instr_pc    = ADDR_W'(head_s.pc);
      end else begin
         instruction = NOP_INSTR;
         instr_pc    = {ADDR_W{1'b0}};
      end
   end

   // PC and in-flight tracking next state; a redirect drops the returning response.
   always_comb begin
      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (issue_s) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
      inflight_d    = issue_s;
      inflight_pc_d = fetch_pc_q;
   end

   // Fetch PC and in-flight read registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= {ADDR_W{1'b0}};
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .flush      (redirect),
      .count      (fifo_count_s),
      .head       (head_s)
   );

endmodule
